// File: rtl/ucode_sequencer.sv
// Step counter and instruction register feeding the microcoded decoder.
// Handles CB-prefix mode, HALT entry/wake and interrupt-dispatch injection.
module ucode_sequencer #(
    parameter int          STEP_W       = 3,
    parameter logic [7:0]  RESET_OPCODE = 8'h00,
    parameter logic [7:0]  INT_OPCODE   = 8'hD3,
    parameter logic [7:0]  CB_PREFIX    = 8'hCB
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [7:0]        db_in,
    input  logic              done,
    input  logic              is_cond,
    input  logic [STEP_W-1:0] next_cond,
    input  logic              halt,
    input  logic [3:0]        flags,
    input  logic              irq_pending,
    input  logic              ime,
    output logic [7:0]        opcode,
    output logic [STEP_W-1:0] step,
    output logic              cb_mode,
    output logic              int_dispatch,
    output logic              int_ack,
    output logic              halted,
    output logic              cc_true,
    output logic              step_err
);

    typedef enum logic {
        S_RUN,
        S_HALT
    } state_t;

    state_t state;

    // N and H never participate in a branch condition.
    logic flags_unused;
    assign flags_unused = ^flags[2:1];

    always_comb begin
        cc_true = 1'b0;
        case (opcode[4:3])
            2'd0: cc_true = ~flags[3];
            2'd1: cc_true =  flags[3];
            2'd2: cc_true = ~flags[0];
            2'd3: cc_true =  flags[0];
            default: cc_true = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_RUN;
            opcode       <= RESET_OPCODE;
            step         <= '0;
            cb_mode      <= 1'b0;
            int_dispatch <= 1'b0;
            int_ack      <= 1'b0;
            halted       <= 1'b0;
            step_err     <= 1'b0;
        end else begin
            int_ack <= 1'b0;
            if (ce) begin
                case (state)
                    S_RUN: begin
                        if (done) begin
                            step <= '0;
                            if (halt) begin
                                state  <= S_HALT;
                                halted <= 1'b1;
                            end else if (opcode == CB_PREFIX && !cb_mode) begin
                                // Second byte of a CB instruction: no interrupt between the two.
                                opcode  <= db_in;
                                cb_mode <= 1'b1;
                            end else if (irq_pending && ime) begin
                                opcode       <= INT_OPCODE;
                                int_dispatch <= 1'b1;
                                cb_mode      <= 1'b0;
                                int_ack      <= 1'b1;
                            end else begin
                                opcode       <= db_in;
                                cb_mode      <= 1'b0;
                                int_dispatch <= 1'b0;
                            end
                        end else if (is_cond && !cc_true) begin
                            step <= next_cond;
                        end else begin
                            step <= step + 1'b1;
                            if (step == '1)
                                step_err <= 1'b1;
                        end
                    end
                    S_HALT: begin
                        step <= '0;
                        if (irq_pending) begin
                            state   <= S_RUN;
                            halted  <= 1'b0;
                            cb_mode <= 1'b0;
                            if (ime) begin
                                opcode       <= INT_OPCODE;
                                int_dispatch <= 1'b1;
                                int_ack      <= 1'b1;
                            end else begin
                                opcode       <= RESET_OPCODE;
                                int_dispatch <= 1'b0;
                            end
                        end
                    end
                    default: state <= S_RUN;
                endcase
            end
        end
    end

endmodule
